// File: rtl/mem_port_arbiter_pkg.sv
// Shared RAM command codes and arbiter state encoding for mem_port_arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] RAM_NONE  = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_D  = 2'd2,
    ARB_ACK     = 2'd3
  } arb_state_e;

  function automatic logic is_ram_req(input logic [1:0] act);
    return (act == RAM_READ) || (act == RAM_WRITE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: counts RAM wait cycles for the current access and flags
// the cycle on which the TIMEOUT-th unanswered cycle elapses.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between fetch and data with data priority and a streak guard.
// Optional saturating completion counters under MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_data,
  input  logic [1:0]  i_d_action,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  output logic [1:0]  o_mem_action,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_err,
  output logic        o_busy,
  output logic [15:0] o_stat_if_cnt,
  output logic [15:0] o_stat_d_cnt
);

  localparam logic [3:0] STREAK_L = 4'(STREAK);

  arb_state_e  state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [1:0]  act_q, act_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        err_q, err_d;
  logic        busy, d_req, wd_clr, wd_exp;

  assign busy  = (state_q == ARB_BUSY_IF) || (state_q == ARB_BUSY_D);
  assign d_req = is_ram_req(i_d_action);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clr_i     (wd_clr),
    .en_i      (busy && !i_mem_ready),
    .expired_o (wd_exp)
  );

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    act_d     = act_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    if_ack_d  = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    wd_clr    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_req && (streak_q < STREAK_L || !i_if_req)) begin
          act_d    = i_d_action;
          addr_d   = i_d_addr;
          wdata_d  = i_d_wdata;
          streak_d = i_if_req ? streak_q + 4'd1 : 4'd0;
          wd_clr   = 1'b1;
          state_d  = ARB_BUSY_D;
        end else if (i_if_req) begin
          act_d    = RAM_READ;
          addr_d   = i_if_addr;
          wdata_d  = '0;
          streak_d = '0;
          wd_clr   = 1'b1;
          state_d  = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_D: begin
        // A timed-out read returns zero rather than stale bus data.
        if (i_mem_ready || wd_exp) begin
          if (state_q == ARB_BUSY_IF) begin
            if_data_d = i_mem_ready ? i_mem_rdata : '0;
            if_ack_d  = 1'b1;
          end else begin
            if (act_q == RAM_READ)
              d_rdata_d = i_mem_ready ? i_mem_rdata : '0;
            d_ack_d = 1'b1;
          end
          err_d   = !i_mem_ready;
          act_d   = RAM_NONE;
          state_d = ARB_ACK;
        end
      end
      ARB_ACK: state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      streak_q  <= '0;
      act_q     <= RAM_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      act_q     <= act_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  assign o_if_ack     = if_ack_q;
  assign o_if_data    = if_data_q;
  assign o_d_ack      = d_ack_q;
  assign o_d_rdata    = d_rdata_q;
  assign o_mem_action = act_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_err        = err_q;
  assign o_busy       = (state_q != ARB_IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_q, stat_if_d;
  logic [15:0] stat_d_q, stat_d_d;

  always_comb begin
    stat_if_d = stat_if_q;
    stat_d_d  = stat_d_q;
    if (if_ack_q && stat_if_q != 16'hFFFF)
      stat_if_d = stat_if_q + 16'd1;
    if (d_ack_q && stat_d_q != 16'hFFFF)
      stat_d_d = stat_d_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_if_q <= '0;
      stat_d_q  <= '0;
    end else begin
      stat_if_q <= stat_if_d;
      stat_d_q  <= stat_d_d;
    end
  end

  assign o_stat_if_cnt = stat_if_q;
  assign o_stat_d_cnt  = stat_d_q;
`else
  assign o_stat_if_cnt = '0;
  assign o_stat_d_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STREAK=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_data;
  logic [1:0]  d_act;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [1:0]  mem_act;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, err, busy;
  logic [15:0] st_if, st_d;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.STREAK(4), .TIMEOUT(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_if_req      (if_req),
    .i_if_addr     (if_addr),
    .o_if_ack      (if_ack),
    .o_if_data     (if_data),
    .i_d_action    (d_act),
    .i_d_addr      (d_addr),
    .i_d_wdata     (d_wdata),
    .o_d_ack       (d_ack),
    .o_d_rdata     (d_rdata),
    .o_mem_action  (mem_act),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ready   (mem_ready),
    .o_err         (err),
    .o_busy        (busy),
    .o_stat_if_cnt (st_if),
    .o_stat_d_cnt  (st_d)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic is_d, input logic [31:0] a);
    if (is_d) begin
      d_act  = RD;
      d_addr = a;
    end else begin
      if_req  = 1'b1;
      if_addr = a;
    end
    mem_ready = 1'b1;
    step();
    step();
    d_act  = NONE;
    if_req = 1'b0;
    step();
  endtask

  logic [15:0] exp_if, exp_d;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_act = NONE; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_act", 32'(mem_act), 32'(NONE));
    chk("rst_ack", 32'({if_ack, d_ack, err}), 0);
    chk("rst_stats", {st_if, st_d}, 0);
    rst = 1'b0;

    // fetch, zero-wait RAM
    if_req = 1'b1; if_addr = 32'h10;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("f1_act", 32'(mem_act), 32'(RD));
    chk("f1_addr", mem_addr, 32'h10);
    chk("f1_noack", 32'(if_ack), 0);
    step();
    chk("f1_ack", 32'(if_ack), 1);
    chk("f1_data", if_data, 32'hDEADBEEF);
    chk("f1_err", 32'(err), 0);
    chk("f1_act_none", 32'(mem_act), 32'(NONE));
    if_req = 1'b0;
    step();
    chk("f1_idle", 32'({busy, if_ack}), 0);

    // simultaneous: data write wins, fetch follows
    if_req = 1'b1; if_addr = 32'h20;
    d_act = WR; d_addr = 32'h40; d_wdata = 32'h5A5A;
    mem_rdata = 32'h1111;
    step();
    chk("s_act", 32'(mem_act), 32'(WR));
    chk("s_addr", mem_addr, 32'h40);
    chk("s_wdata", mem_wdata, 32'h5A5A);
    step();
    chk("s_dack", 32'({d_ack, if_ack}), 32'b10);
    chk("s_rdata_kept", d_rdata, 0);
    d_act = NONE;
    step();
    chk("s_idle", 32'(busy), 0);
    step();
    chk("s_f_act", 32'(mem_act), 32'(RD));
    chk("s_f_addr", mem_addr, 32'h20);
    step();
    chk("s_f_ack", 32'(if_ack), 1);
    chk("s_f_data", if_data, 32'h1111);
    if_req = 1'b0;
    step();

    // streak guard: 4 data, 1 fetch, repeat
    if_req = 1'b1; if_addr = 32'h100;
    d_act = RD; d_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      mem_rdata = 32'hA000 + 32'(k);
      step();
      chk($sformatf("st_addr%0d", k), mem_addr,
          (k % 5 == 4) ? 32'h100 : 32'h200);
      step();
      chk($sformatf("st_ack%0d", k), 32'({d_ack, if_ack}),
          (k % 5 == 4) ? 32'b01 : 32'b10);
      step();
    end
    if_req = 1'b0; d_act = NONE;
    chk("st_rdata", d_rdata, 32'hA008);
    step();

    // timeout: RAM never ready
    d_act = RD; d_addr = 32'h300;
    mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF;
    step();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_hold%0d", i), 32'({mem_act, d_ack, err}),
          32'({RD, 1'b0, 1'b0}));
      step();
    end
    chk("to_act", 32'(mem_act), 32'(NONE));
    chk("to_ack_err", 32'({d_ack, err}), 32'b11);
    chk("to_rdata", d_rdata, 0);
    d_act = NONE;
    step();
    chk("to_clear", 32'({d_ack, err, busy}), 0);

    // reset mid-access, late ready ignored
    d_act = RD; d_addr = 32'h400; mem_rdata = 32'h7777;
    step();
    chk("r_busy", 32'(busy), 1);
    step();
    rst = 1'b1;
    step();
    chk("r_outs", 32'({busy, mem_act, d_ack, if_ack, err}), 0);
    chk("r_addr", mem_addr, 0);
    chk("r_data", if_data | d_rdata, 0);
    rst = 1'b0; d_act = NONE; mem_ready = 1'b1;
    step();
    chk("r_late1", 32'({d_ack, busy, mem_act}), 0);
    step();
    chk("r_late2", 32'({d_ack, busy, d_rdata[15:0]}), 0);

    // completion counters
    access(1'b0, 32'h500);
    access(1'b1, 32'h600);
    access(1'b0, 32'h504);
    access(1'b1, 32'h604);
    access(1'b0, 32'h508);
`ifdef MEM_ARB_STATS_EN
    exp_if = 16'd3; exp_d = 16'd2;
`else
    exp_if = 16'd0; exp_d = 16'd0;
`endif
    chk("stat_if", 32'(st_if), 32'(exp_if));
    chk("stat_d", 32'(st_d), 32'(exp_d));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single RAM port between two requesters: instruction fetch (IF) and the data access issued by the control unit for LD/LDA/ST.
- Sequences each access as a multi-cycle handshake with a variable-latency RAM.
- Arbitrates with data priority, a fetch anti-starvation guard, and a watchdog timeout.
- Sits between the control/fetch logic and the RAM model.

Parameters:
STREAK, 4, max consecutive data grants while IF is pending before IF is forced through (1..15)
TIMEOUT, 255, cycles waited for i_mem_ready before the access is aborted (1..255)

Ports:
i_clk  in  1  clock, all state updates on posedge
i_rst  in  1  synchronous reset, active-high
i_if_req  in  1  fetch request, held until o_if_ack
i_if_addr  in  32  fetch address
o_if_ack  out  1  one-cycle fetch completion pulse
o_if_data  out  32  fetched word, valid with o_if_ack, held until the next fetch ack
i_d_action  in  2  RAM_NONE/RAM_READ/RAM_WRITE from control; non-NONE = request, held until o_d_ack
i_d_addr  in  32  data address
i_d_wdata  in  32  store data
o_d_ack  out  1  one-cycle data completion pulse
o_d_rdata  out  32  load data, valid with o_d_ack on reads; unchanged on writes
o_mem_action  out  2  registered RAM command
o_mem_addr  out  32  registered RAM address
o_mem_wdata  out  32  registered RAM write data
i_mem_rdata  in  32  RAM read data, valid when i_mem_ready
i_mem_ready  in  1  RAM completes the current command this cycle
o_err  out  1  one-cycle pulse, coincident with the ack, when an access timed out
o_busy  out  1  high in any state other than IDLE
o_stat_if_cnt  out  16  completed fetch count (optional feature)
o_stat_d_cnt  out  16  completed data-access count (optional feature)

Behaviour:
- Reset (i_rst=1 at posedge, including mid-access):
  - state=IDLE; all outputs 0, including o_mem_action=RAM_NONE.
  - streak and timeout counters 0.
  - The aborted access is never acked.
- States: IDLE, BUSY_IF, BUSY_D, ACK.
- IDLE:
  - If i_d_action!=NONE and (streak<STREAK or !i_if_req): grant data. Load o_mem_* from the data inputs; streak+=1 if i_if_req else streak=0; go to BUSY_D.
  - Else if i_if_req: grant fetch. o_mem_action=RAM_READ, o_mem_addr=i_if_addr; streak=0; go to BUSY_IF.
  - i_d_action=2'b11 is treated as NONE.
- BUSY_*:
  - o_mem_* held constant.
  - On i_mem_ready: capture i_mem_rdata into o_if_data (fetch) or o_d_rdata (data reads only); pulse the matching ack in the next cycle; o_mem_action=NONE; go to ACK.
  - Timeout counter increments each BUSY cycle without ready. On reaching TIMEOUT: o_mem_action=NONE; data output forced to 0 for reads; ack plus o_err pulsed next cycle; go to ACK.
  - Timeout counter clears on entry to BUSY.
- ACK:
  - Exactly one cycle. Ack high; no new grant is made.
  - Next state IDLE. The requester must drop its request by the end of this cycle.
- Latency with a zero-wait RAM (ready in the first BUSY cycle): request sampled at edge N → command visible after N → ack high after N+1 → IDLE after N+2. Back-to-back accesses therefore take 3 cycles each.
- Simultaneous IF and data requests in IDLE: data wins unless streak==STREAK.
- Request dropped while BUSY: the access still completes and is acked; the ack is ignored by the requester.
- i_mem_ready outside BUSY is ignored.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - o_stat_if_cnt / o_stat_d_cnt increment on each o_if_ack / o_d_ack, including timed-out accesses.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: both ports driven constant 0; no counter flops.

Decomposition:
- Shared defines include carries:
  - RAM_NONE=2'd0, RAM_READ=2'd1, RAM_WRITE=2'd2.
  - New ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_D/ARB_ACK state codes (2 bits).
- One natural sub-module, arb_watchdog: the loadable timeout counter with a clear input and an expired output.
- Arbitration, FSM and the stats counters stay in mem_port_arbiter.

Test Plan:
- Fetch only, zero-wait RAM, i_if_addr=32'h10, i_mem_rdata=32'hDEADBEEF → o_mem_action=READ, addr=0x10 one cycle after request; o_if_ack one cycle later with o_if_data=32'hDEADBEEF; o_err=0.
- Simultaneous i_if_req and i_d_action=WRITE (addr 0x40, wdata 0x5A5A) → data granted first with o_mem_action=WRITE, wdata 0x5A5A; fetch granted in the IDLE after the data ack; o_d_rdata unchanged.
- Continuous data reads with i_if_req held, STREAK=4 → exactly 4 data grants, then 1 fetch grant, pattern repeats.
- RAM never ready, TIMEOUT=8, data read → o_mem_action returns to NONE after 8 busy cycles; o_d_ack and o_err pulse together; o_d_rdata=0.
- i_rst asserted in BUSY_D with ready 2 cycles later → no ack; all outputs 0 the cycle after reset; late i_mem_ready ignored.
- With MEM_ARB_STATS_EN: 3 fetches and 2 data accesses → o_stat_if_cnt=3, o_stat_d_cnt=2. Without the macro: both read 0.
